// File: rtl/i2s_adc_receiver.sv
// Slave-mode I2S capture for the WM8731 ADC path: synchronises BCLK/ADCLRC/ADCDAT into CLK,
// decodes left/right sample pairs and hands them out over a valid/ready handshake.
module i2s_adc_receiver #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BCLK,
    input  logic                  ADCLRC,
    input  logic                  ADCDAT,
    input  logic                  ENABLE,
    input  logic                  FLAG_CLR,
    output logic [DATA_WIDTH-1:0] LEFT_DATA,
    output logic [DATA_WIDTH-1:0] RIGHT_DATA,
    output logic                  DATA_VALID,
    input  logic                  DATA_READY,
    output logic                  OVERFLOW,
    output logic                  FRAME_ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_LEFT,
        S_RIGHT
    } state_t;

    localparam logic [5:0] WIDTH_CNT = 6'(DATA_WIDTH);

    state_t state;
    state_t next_state;

    logic bclk_meta;
    logic bclk_sync;
    logic bclk_prev;
    logic lrc_meta;
    logic lrc_s;
    logic lrc_prev;
    logic dat_meta;
    logic dat_s;

    logic bclk_rise;
    logic boundary;

    logic [5:0]            cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [DATA_WIDTH-1:0] right_hold;
    logic                  pair_done;

    logic frame_err_set;
    logic latch_left;
    logic pair_cap;
    logic overflow_set;

    always_comb begin
        bclk_rise  = bclk_sync & ~bclk_prev;
        boundary   = bclk_rise & (lrc_s ^ lrc_prev);
        shift_next = DATA_WIDTH'({shift, dat_s});
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        frame_err_set = 1'b0;
        latch_left    = 1'b0;
        pair_cap      = 1'b0;
        if (!ENABLE) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = S_SYNC;
                S_SYNC: begin
                    if (boundary && !lrc_s) begin
                        next_state = S_LEFT;
                    end
                end
                S_LEFT: begin
                    if (boundary) begin
                        if (cnt == WIDTH_CNT) begin
                            latch_left = 1'b1;
                            next_state = S_RIGHT;
                        end else begin
                            frame_err_set = 1'b1;
                            next_state    = S_SYNC;
                        end
                    end
                end
                S_RIGHT: begin
                    if (boundary) begin
                        if (cnt == WIDTH_CNT) begin
                            next_state = S_LEFT;
                        end else begin
                            frame_err_set = 1'b1;
                            next_state    = S_SYNC;
                        end
                    end else if (bclk_rise && cnt == WIDTH_CNT - 6'd1) begin
                        pair_cap = 1'b1;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Shifter, counter and the pair-complete pulse; the pulse adds one cycle so the
    // output stage sees a stable registered pair.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bclk_meta  <= 1'b0;
            bclk_sync  <= 1'b0;
            bclk_prev  <= 1'b0;
            lrc_meta   <= 1'b0;
            lrc_s      <= 1'b0;
            lrc_prev   <= 1'b0;
            dat_meta   <= 1'b0;
            dat_s      <= 1'b0;
            cnt        <= '0;
            shift      <= '0;
            left_hold  <= '0;
            right_hold <= '0;
            pair_done  <= 1'b0;
        end else begin
            bclk_meta <= BCLK;
            bclk_sync <= bclk_meta;
            bclk_prev <= bclk_sync;
            lrc_meta  <= ADCLRC;
            lrc_s     <= lrc_meta;
            dat_meta  <= ADCDAT;
            dat_s     <= dat_meta;
            if (bclk_rise) begin
                lrc_prev <= lrc_s;
            end
            if (!ENABLE || state == S_IDLE) begin
                cnt   <= '0;
                shift <= '0;
            end else if (bclk_rise) begin
                if (boundary) begin
                    cnt <= '0;
                end else if (cnt < WIDTH_CNT) begin
                    shift <= shift_next;
                    cnt   <= cnt + 6'd1;
                end
            end
            if (latch_left) begin
                left_hold <= shift;
            end
            if (pair_cap) begin
                right_hold <= shift_next;
            end
            pair_done <= pair_cap;
        end
    end

    assign overflow_set = pair_done & DATA_VALID & ~DATA_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            LEFT_DATA  <= '0;
            RIGHT_DATA <= '0;
            DATA_VALID <= 1'b0;
            OVERFLOW   <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            if (pair_done) begin
                if (!DATA_VALID || DATA_READY) begin
                    LEFT_DATA  <= left_hold;
                    RIGHT_DATA <= right_hold;
                    DATA_VALID <= 1'b1;
                end
            end else if (DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
            // A same-cycle set wins over FLAG_CLR.
            if (overflow_set) begin
                OVERFLOW <= 1'b1;
            end else if (FLAG_CLR) begin
                OVERFLOW <= 1'b0;
            end
            if (frame_err_set) begin
                FRAME_ERR <= 1'b1;
            end else if (FLAG_CLR) begin
                FRAME_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: a behavioural I2S master drives BCLK = CLK/4 frames
// and a monitor records every accepted pair for comparison against hand-computed values.
module tb_i2s_adc_receiver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        BCLK;
    logic        ADCLRC;
    logic        ADCDAT;
    logic        ENABLE;
    logic        FLAG_CLR;
    logic [23:0] LEFT_DATA;
    logic [23:0] RIGHT_DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        OVERFLOW;
    logic        FRAME_ERR;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int          cyc        = 0;
    int          rise_cyc   = 0;
    int          lsb_edge   = 0;
    logic        prev_valid = 1'b0;
    logic [47:0] xq[$];
    int          base;

    i2s_adc_receiver #(.DATA_WIDTH(24)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BCLK      (BCLK),
        .ADCLRC    (ADCLRC),
        .ADCDAT    (ADCDAT),
        .ENABLE    (ENABLE),
        .FLAG_CLR  (FLAG_CLR),
        .LEFT_DATA (LEFT_DATA),
        .RIGHT_DATA(RIGHT_DATA),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .OVERFLOW  (OVERFLOW),
        .FRAME_ERR (FRAME_ERR)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Inputs move on negedge; sampling 2 ns later sees settled outputs and the READY
    // that the next posedge will use, so each push is exactly one accepted transfer.
    always @(negedge CLK) begin
        #2;
        if (DATA_VALID && !prev_valid) rise_cyc = cyc;
        prev_valid = DATA_VALID;
        if (DATA_VALID && DATA_READY) xq.push_back({LEFT_DATA, RIGHT_DATA});
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] last_pair();
        if (xq.size() == 0) return 48'hx;
        return xq[xq.size()-1];
    endfunction

    // One slot: index 0 is the boundary bit, indices 1..24 carry MSB..LSB.
    task automatic send_slot(input logic lrc, input logic [23:0] data, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            @(negedge CLK);
            BCLK   = 1'b0;
            ADCLRC = lrc;
            ADCDAT = (i >= 1 && i <= 24) ? data[24-i] : 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            BCLK = 1'b1;
            if (lrc && i == 24) lsb_edge = cyc + 1;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    initial begin
        RST        = 1'b1;
        BCLK       = 1'b0;
        ADCLRC     = 1'b0;
        ADCDAT     = 1'b0;
        ENABLE     = 1'b0;
        FLAG_CLR   = 1'b0;
        DATA_READY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_left", 48'(LEFT_DATA), 48'h0);
        check("rst_right", 48'(RIGHT_DATA), 48'h0);
        check("rst_valid", 48'(DATA_VALID), 48'h0);
        check("rst_ovf", 48'(OVERFLOW), 48'h0);
        check("rst_ferr", 48'(FRAME_ERR), 48'h0);
        RST = 1'b0;

        // Enable mid right slot, then three nominal frames.
        send_slot(1'b1, 24'h0F0F0F, 10);
        ENABLE = 1'b1;
        send_slot(1'b1, 24'h0F0F0F, 22);
        base = xq.size();
        repeat (3) send_frame(24'hABCDEF, 24'h123456);
        check("nom_count", 48'(xq.size() - base), 48'd3);
        check("nom_pair", last_pair(), {24'hABCDEF, 24'h123456});
        check("nom_outputs", {LEFT_DATA, RIGHT_DATA}, {24'hABCDEF, 24'h123456});
        check("nom_latency", 48'(rise_cyc - lsb_edge), 48'd3);
        check("nom_valid_low", 48'(DATA_VALID), 48'h0);
        check("nom_ovf", 48'(OVERFLOW), 48'h0);
        check("nom_ferr", 48'(FRAME_ERR), 48'h0);

        // Back-pressure: first pair held, second dropped.
        DATA_READY = 1'b0;
        base = xq.size();
        send_frame(24'h000001, 24'h800000);
        check("bp_valid1", 48'(DATA_VALID), 48'h1);
        check("bp_pair1", {LEFT_DATA, RIGHT_DATA}, {24'h000001, 24'h800000});
        check("bp_ovf_early", 48'(OVERFLOW), 48'h0);
        send_frame(24'h7FFFFF, 24'hFFFFFF);
        check("bp_ovf", 48'(OVERFLOW), 48'h1);
        check("bp_pair_kept", {LEFT_DATA, RIGHT_DATA}, {24'h000001, 24'h800000});
        DATA_READY = 1'b1;
        repeat (2) @(negedge CLK);
        check("bp_count", 48'(xq.size() - base), 48'd1);
        check("bp_accepted", last_pair(), {24'h000001, 24'h800000});
        check("bp_valid_clr", 48'(DATA_VALID), 48'h0);
        check("bp_ovf_still", 48'(OVERFLOW), 48'h1);
        FLAG_CLR = 1'b1;
        @(negedge CLK);
        FLAG_CLR = 1'b0;
        @(negedge CLK);
        check("bp_ovf_cleared", 48'(OVERFLOW), 48'h0);

        // Short left slot: framing error, then recovery.
        base = xq.size();
        send_slot(1'b0, 24'h999999, 16);
        send_slot(1'b1, 24'h888888, 32);
        check("short_ferr", 48'(FRAME_ERR), 48'h1);
        check("short_no_pair", 48'(xq.size() - base), 48'd0);
        send_frame(24'h555555, 24'hAAAAAA);
        check("short_count", 48'(xq.size() - base), 48'd1);
        check("short_recover", last_pair(), {24'h555555, 24'hAAAAAA});
        FLAG_CLR = 1'b1;
        @(negedge CLK);
        FLAG_CLR = 1'b0;
        @(negedge CLK);
        check("short_ferr_clr", 48'(FRAME_ERR), 48'h0);

        // Disable during a left slot with a pair pending.
        DATA_READY = 1'b0;
        base = xq.size();
        send_frame(24'h13579B, 24'h2468AC);
        check("dis_pending", 48'(DATA_VALID), 48'h1);
        send_slot(1'b0, 24'h111111, 11);
        ENABLE = 1'b0;
        send_slot(1'b1, 24'h444444, 32);
        send_frame(24'h222222, 24'h333333);
        check("dis_valid_held", 48'(DATA_VALID), 48'h1);
        check("dis_pair_held", {LEFT_DATA, RIGHT_DATA}, {24'h13579B, 24'h2468AC});
        check("dis_ovf", 48'(OVERFLOW), 48'h0);
        DATA_READY = 1'b1;
        repeat (2) @(negedge CLK);
        check("dis_count", 48'(xq.size() - base), 48'd1);
        check("dis_delivered", last_pair(), {24'h13579B, 24'h2468AC});
        check("dis_valid_clr", 48'(DATA_VALID), 48'h0);

        // Reset at bit 10 of a left slot.
        ENABLE = 1'b1;
        send_slot(1'b1, 24'h0, 32);
        send_slot(1'b0, 24'h3C3C3C, 11);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mrst_left", 48'(LEFT_DATA), 48'h0);
        check("mrst_right", 48'(RIGHT_DATA), 48'h0);
        check("mrst_valid", 48'(DATA_VALID), 48'h0);
        base = xq.size();
        send_slot(1'b1, 24'h5A5A5A, 32);
        check("mrst_no_pair", 48'(xq.size() - base), 48'd0);
        send_frame(24'hCAFE01, 24'hBEEF02);
        check("mrst_count", 48'(xq.size() - base), 48'd1);
        check("mrst_pair", last_pair(), {24'hCAFE01, 24'hBEEF02});
        check("mrst_ferr", 48'(FRAME_ERR), 48'h0);

        // Loopback of a counting source over 100 frames.
        xq.delete();
        for (int k = 0; k < 100; k++) send_frame(24'(2 * k), 24'(2 * k + 1));
        check("loop_count", 48'(xq.size()), 48'd100);
        for (int k = 0; k < 100 && k < xq.size(); k++)
            check($sformatf("loop_pair%0d", k), xq[k], {24'(2 * k), 24'(2 * k + 1)});
        check("loop_ovf", 48'(OVERFLOW), 48'h0);
        check("loop_ferr", 48'(FRAME_ERR), 48'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
